// File: rtl/lbus_pkg.sv
// Shared local-bus definitions: request record and the read-detect rule,
// common to the arbiter and the lbus-to-AXI3 bridge.
package lbus_pkg;

  localparam int LBUS_ID_W   = 2;
  localparam int LBUS_ADDR_W = 8;
  localparam int LBUS_DATA_W = 32;
  localparam int LBUS_STRB_W = LBUS_DATA_W / 8;

  typedef struct packed {
    logic [LBUS_ID_W-1:0]   id;
    logic [LBUS_STRB_W-1:0] strb;
    logic [LBUS_ADDR_W-1:0] addr;
    logic [LBUS_DATA_W-1:0] data;
  } lbus_req_t;

  // A request carrying no byte enables is a read.
  function automatic logic lbus_is_read(input logic [LBUS_STRB_W-1:0] strb);
    return (strb == '0);
  endfunction

endpackage

// File: rtl/lbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N, returned both one-hot and as an index.
module rr_pick #(
  parameter int N    = 4,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IdxW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lbus_arbiter.sv
// Round-robin merge of NumMst local-bus masters onto the bridge's single lbus
// port; one transaction in flight, completions routed back by id.
module lbus_arbiter
  import lbus_pkg::*;
#(
  parameter  int NumMst = 4,
  parameter  int AddrW  = 8,
  parameter  int DataW  = 32,
  parameter  int IdW    = 2,
  localparam int StrbW  = DataW / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumMst-1:0]         m_req,
  input  logic [NumMst*StrbW-1:0]   m_strb,
  input  logic [NumMst*AddrW-1:0]   m_addr,
  input  logic [NumMst*DataW-1:0]   m_wdata,
  output logic [NumMst-1:0]         m_acko,
  output logic [NumMst-1:0]         m_readyo,
  output logic [DataW-1:0]          m_rdatao,
  output logic                      bus_reqo,
  output logic [IdW-1:0]            bus_ido,
  output logic [StrbW-1:0]          bus_strbo,
  output logic [AddrW-1:0]          bus_addro,
  output logic [DataW-1:0]          bus_wdatao,
  input  logic                      bus_ready,
  input  logic [IdW-1:0]            bus_id,
  input  logic [DataW-1:0]          bus_rdata,
  input  logic                      bus_busy
);

  localparam int PtrW = $clog2(NumMst);

  logic              r_req;
  logic [PtrW-1:0]   ptr;
  logic [NumMst-1:0] gnt_oh;
  logic [PtrW-1:0]   gnt_idx;
  logic              gnt_any;
  logic              issue_ok;

  rr_pick #(.N(NumMst), .IdxW(PtrW)) u_pick (
    .req   (m_req),
    .ptr   (ptr),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // r_req covers the cycle before the bridge's busy flag rises.
  assign issue_ok = !bus_busy && !r_req && gnt_any;
  assign bus_reqo = r_req;

  // Issue stage: payload registers load only on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= 1'b0;
      m_acko     <= '0;
      ptr        <= '0;
      bus_ido    <= '0;
      bus_strbo  <= '0;
      bus_addro  <= '0;
      bus_wdatao <= '0;
    end else begin
      r_req  <= issue_ok;
      m_acko <= issue_ok ? gnt_oh : '0;
      if (issue_ok) begin
        ptr        <= (gnt_idx == PtrW'(NumMst - 1)) ? '0 : gnt_idx + 1'b1;
        bus_ido    <= IdW'(gnt_idx);
        bus_strbo  <= m_strb[gnt_idx*StrbW +: StrbW];
        bus_addro  <= m_addr[gnt_idx*AddrW +: AddrW];
        bus_wdatao <= m_wdata[gnt_idx*DataW +: DataW];
      end
    end
  end

  // Completions route straight through; ids beyond NumMst match no master.
  always_comb begin
    m_readyo = '0;
    for (int i = 0; i < NumMst; i++) begin
      m_readyo[i] = bus_ready && (bus_id == IdW'(i));
    end
  end

  assign m_rdatao = bus_rdata;

endmodule

// File: tb/tb_lbus_arbiter.sv
// Bench for lbus_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference model of the arbitration rules and a simple bridge.
module tb_lbus_arbiter;

  localparam int NumMst = 4;
  localparam int AddrW  = 8;
  localparam int DataW  = 32;
  localparam int IdW    = 2;
  localparam int StrbW  = DataW / 8;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NumMst-1:0]       m_req = '0;
  logic [NumMst*StrbW-1:0] m_strb = '0;
  logic [NumMst*AddrW-1:0] m_addr = '0;
  logic [NumMst*DataW-1:0] m_wdata = '0;
  logic [NumMst-1:0]       m_acko;
  logic [NumMst-1:0]       m_readyo;
  logic [DataW-1:0]        m_rdatao;
  logic                    bus_reqo;
  logic [IdW-1:0]          bus_ido;
  logic [StrbW-1:0]        bus_strbo;
  logic [AddrW-1:0]        bus_addro;
  logic [DataW-1:0]        bus_wdatao;
  logic                    bus_ready = 1'b0;
  logic [IdW-1:0]          bus_id = '0;
  logic [DataW-1:0]        bus_rdata = '0;
  logic                    bus_busy = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  lbus_arbiter #(.NumMst(NumMst), .AddrW(AddrW), .DataW(DataW), .IdW(IdW)) dut (
    .clk        (clk),
    .reset      (reset),
    .m_req      (m_req),
    .m_strb     (m_strb),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_acko     (m_acko),
    .m_readyo   (m_readyo),
    .m_rdatao   (m_rdatao),
    .bus_reqo   (bus_reqo),
    .bus_ido    (bus_ido),
    .bus_strbo  (bus_strbo),
    .bus_addro  (bus_addro),
    .bus_wdatao (bus_wdatao),
    .bus_ready  (bus_ready),
    .bus_id     (bus_id),
    .bus_rdata  (bus_rdata),
    .bus_busy   (bus_busy)
  );

  always #5 clk = ~clk;

  // Master protocol: request and payload held until the accept pulse.
  logic [NumMst-1:0]       hold_q = '0;
  logic [NumMst*StrbW-1:0] strb_q = '0;
  logic [NumMst*AddrW-1:0] addr_q = '0;
  logic [NumMst*DataW-1:0] data_q = '0;
  always @(negedge clk) begin
    for (int i = 0; i < NumMst; i++) begin
      if (!reset && hold_q[i]) begin
        assert (m_req[i] && m_strb[i*StrbW +: StrbW] == strb_q[i*StrbW +: StrbW]
                && m_addr[i*AddrW +: AddrW] == addr_q[i*AddrW +: AddrW]
                && m_wdata[i*DataW +: DataW] == data_q[i*DataW +: DataW])
          else $error("master %0d dropped request or changed payload before accept", i);
      end
    end
    hold_q <= reset ? '0 : (m_req & ~m_acko);
    strb_q <= m_strb;
    addr_q <= m_addr;
    data_q <= m_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [StrbW-1:0] s,
                       input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
    m_strb[i*StrbW +: StrbW]  = s;
    m_addr[i*AddrW +: AddrW]  = a;
    m_wdata[i*DataW +: DataW] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b0 || m_acko !== 4'b0 || m_readyo !== 4'b0)
      $display("FAIL reset_ctrl: reqo=%b acko=%b readyo=%b want 0/0000/0000", bus_reqo, m_acko, m_readyo);
    else n_pass++;
    n_chk++;
    if (bus_ido !== 2'd0 || bus_strbo !== 4'h0 || bus_addro !== 8'h00 || bus_wdatao !== 32'h0)
      $display("FAIL reset_payload: id=%h strb=%h addr=%h data=%h want all 0", bus_ido, bus_strbo, bus_addro, bus_wdatao);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int last_t = -1;
    int busy_left = 0;
    logic [NumMst-1:0] pend = '0;
    logic [NumMst-1:0] ack_prev = '0;
    logic stop = 1'b0;
    logic done = 1'b0;
    for (int i = 0; i < NumMst; i++) set_m(i, 4'hF, AddrW'(8'h40 + i), DataW'(32'hA000 + i));
    for (int c = 0; c < 200 && !done; c++) begin
      for (int i = 0; i < NumMst; i++) begin
        if (ack_prev[i]) begin
          m_req[i] = 1'b0;
          pend[i]  = 1'b0;
        end else if (!pend[i] && !stop) begin
          m_req[i] = 1'b1;
          pend[i]  = 1'b1;
        end
      end
      bus_busy  = (busy_left > 0);
      bus_ready = bus_reqo;
      bus_id    = bus_ido;
      #1;
      if (bus_reqo) begin
        if (order.size() < 5) begin
          order.push_back(int'(bus_ido));
          if (last_t >= 0) begin
            n_chk++;
            if (c - last_t !== 5) $display("FAIL rr_spacing: gap=%0d cycles want 5", c - last_t);
            else n_pass++;
          end
        end
        last_t = c;
      end
      ack_prev = m_acko;
      if (busy_left > 0) busy_left--;
      if (bus_reqo) busy_left = 3;
      if (order.size() >= 5) stop = 1'b1;
      if (stop && pend == '0 && busy_left == 0 && m_acko == '0 && !bus_reqo) done = 1'b1;
      tick();
    end
    bus_busy  = 1'b0;
    bus_ready = 1'b0;
    m_req     = '0;
    n_chk++;
    if (!done) $display("FAIL rr_timeout: round-robin scenario did not drain, grants seen=%0d want 5", order.size());
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (k >= order.size()) $display("FAIL rr_order[%0d]: no grant observed want %0d", k, exp_order[k]);
      else if (order[k] !== exp_order[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]);
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    set_m(1, 4'hF, 8'h10, 32'hDEADBEEF);
    m_req = 4'b0010;
    tick();
    bus_ready = 1'b1;
    bus_id    = 2'd1;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd1)
      $display("FAIL wr_issue: reqo=%b id=%0d want 1/1", bus_reqo, bus_ido);
    else n_pass++;
    n_chk++;
    if (bus_strbo !== 4'hF || bus_addro !== 8'h10 || bus_wdatao !== 32'hDEADBEEF)
      $display("FAIL wr_payload: strb=%h addr=%h data=%h want f/10/deadbeef", bus_strbo, bus_addro, bus_wdatao);
    else n_pass++;
    n_chk++;
    if (m_acko !== 4'b0010 || m_readyo !== 4'b0010)
      $display("FAIL wr_ack_ready: acko=%b readyo=%b want 0010/0010", m_acko, m_readyo);
    else n_pass++;
    tick();
    m_req     = '0;
    bus_ready = 1'b0;
    bus_busy  = 1'b1;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b0 || m_acko !== 4'b0)
      $display("FAIL wr_one_pulse: reqo=%b acko=%b want 0/0000", bus_reqo, m_acko);
    else n_pass++;
    tick();
    bus_busy = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set_m(2, 4'h0, 8'h20, 32'h0);
    m_req = 4'b0100;
    tick();
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd2 || bus_strbo !== 4'h0 || bus_addro !== 8'h20)
      $display("FAIL rd_issue: reqo=%b id=%0d strb=%h addr=%h want 1/2/0/20", bus_reqo, bus_ido, bus_strbo, bus_addro);
    else n_pass++;
    n_chk++;
    if (m_acko !== 4'b0100 || m_readyo !== 4'b0)
      $display("FAIL rd_ack: acko=%b readyo=%b want 0100/0000", m_acko, m_readyo);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      m_req    = '0;
      bus_busy = 1'b1;
      if (k == 4) begin
        bus_ready = 1'b1;
        bus_id    = 2'd2;
        bus_rdata = 32'h12345678;
      end
      #1;
      n_chk++;
      if (k < 4 && m_readyo !== 4'b0) $display("FAIL rd_early_ready: cycle %0d readyo=%b want 0000", k, m_readyo);
      else if (k == 4 && (m_readyo !== 4'b0100 || m_rdatao !== 32'h12345678))
        $display("FAIL rd_data: readyo=%b rdata=%h want 0100/12345678", m_readyo, m_rdatao);
      else n_pass++;
    end
    tick();
    bus_busy  = 1'b0;
    bus_ready = 1'b0;
    tick();
  endtask

  task automatic test_wrap_skip();
    set_m(0, 4'hF, 8'h01, 32'h0000_0A0A);
    set_m(2, 4'h3, 8'h02, 32'h0000_0B0B);
    m_req = 4'b0101;
    tick();
    bus_ready = 1'b1;
    bus_id    = bus_ido;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd0 || m_acko !== 4'b0001 || bus_addro !== 8'h01)
      $display("FAIL wrap_grant0: reqo=%b id=%0d acko=%b addr=%h want 1/0/0001/01", bus_reqo, bus_ido, m_acko, bus_addro);
    else n_pass++;
    tick();
    m_req     = 4'b0100;
    bus_ready = 1'b0;
    bus_busy  = 1'b1;
    tick();
    bus_busy = 1'b0;
    tick();
    bus_ready = 1'b1;
    bus_id    = bus_ido;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd2 || m_acko !== 4'b0100 || bus_strbo !== 4'h3)
      $display("FAIL wrap_grant2: reqo=%b id=%0d acko=%b strb=%h want 1/2/0100/3", bus_reqo, bus_ido, m_acko, bus_strbo);
    else n_pass++;
    tick();
    m_req     = '0;
    bus_ready = 1'b0;
    bus_busy  = 1'b1;
    tick();
    bus_busy = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    set_m(3, 4'hC, 8'h33, 32'hCAFE0003);
    m_req    = 4'b1000;
    bus_busy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      n_chk++;
      if (bus_reqo !== 1'b0 || m_acko !== 4'b0)
        $display("FAIL bp_hold: cycle %0d reqo=%b acko=%b want 0/0000", k, bus_reqo, m_acko);
      else n_pass++;
      tick();
    end
    bus_busy = 1'b0;
    tick();
    bus_ready = 1'b1;
    bus_id    = 2'd3;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd3 || m_acko !== 4'b1000 || bus_wdatao !== 32'hCAFE0003)
      $display("FAIL bp_release: reqo=%b id=%0d acko=%b data=%h want 1/3/1000/cafe0003", bus_reqo, bus_ido, m_acko, bus_wdatao);
    else n_pass++;
    tick();
    m_req     = '0;
    bus_ready = 1'b0;
    bus_busy  = 1'b1;
    tick();
    bus_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_m(1, 4'h0, 8'h30, 32'h0);
    m_req = 4'b0010;
    tick();
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd1)
      $display("FAIL rst_mid_issue: reqo=%b id=%0d want 1/1", bus_reqo, bus_ido);
    else n_pass++;
    tick();
    m_req    = '0;
    bus_busy = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    bus_busy = 1'b0;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b0 || m_acko !== 4'b0 || m_readyo !== 4'b0 || bus_ido !== 2'd0 ||
        bus_strbo !== 4'h0 || bus_addro !== 8'h00 || bus_wdatao !== 32'h0)
      $display("FAIL rst_mid_outputs: reqo=%b acko=%b id=%0d addr=%h want all 0", bus_reqo, m_acko, bus_ido, bus_addro);
    else n_pass++;
    set_m(1, 4'hF, 8'h31, 32'h1111_0001);
    set_m(3, 4'hF, 8'h3C, 32'h3333_0003);
    m_req = 4'b1010;
    tick();
    bus_ready = 1'b1;
    bus_id    = bus_ido;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd1 || m_acko !== 4'b0010)
      $display("FAIL rst_mid_ptr: reqo=%b id=%0d acko=%b want 1/1/0010", bus_reqo, bus_ido, m_acko);
    else n_pass++;
    tick();
    m_req     = 4'b1000;
    bus_ready = 1'b0;
    bus_busy  = 1'b1;
    tick();
    bus_busy = 1'b0;
    tick();
    bus_ready = 1'b1;
    bus_id    = bus_ido;
    #1;
    n_chk++;
    if (bus_reqo !== 1'b1 || bus_ido !== 2'd3 || m_acko !== 4'b1000 || bus_addro !== 8'h3C)
      $display("FAIL rst_mid_m3: reqo=%b id=%0d acko=%b addr=%h want 1/3/1000/3c", bus_reqo, bus_ido, m_acko, bus_addro);
    else n_pass++;
    tick();
    m_req     = '0;
    bus_ready = 1'b0;
    bus_busy  = 1'b1;
    tick();
    bus_busy = 1'b0;
    tick();
  endtask

  // Randomized traffic; the model tracks the pointer, the single in-flight
  // slot and the bridge, and predicts every registered output one cycle ahead.
  task automatic test_random(input int start_ptr);
    int                e_ptr = start_ptr;
    logic              e_req = 1'b0;
    int                e_id = 0;
    logic [NumMst-1:0] e_ack = '0;
    int                busy_left = 0;
    logic              rd_pend = 1'b0;
    int                rd_id = 0;
    logic              rd_done;
    logic [NumMst-1:0] pend = '0;
    logic [NumMst-1:0] just_ack = '0;
    logic [NumMst-1:0] exp_rdy;
    logic [StrbW-1:0]  ps[NumMst];
    logic [AddrW-1:0]  pa[NumMst];
    logic [DataW-1:0]  pd[NumMst];
    logic              done = 1'b0;
    int                g;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      for (int i = 0; i < NumMst; i++) begin
        if (just_ack[i]) begin
          pend[i]  = 1'b0;
          m_req[i] = 1'b0;
        end else if (!pend[i] && cyc < 400 && $urandom_range(0, 2) == 0) begin
          ps[i] = ($urandom_range(0, 2) == 0) ? 4'h0 : StrbW'($urandom);
          pa[i] = AddrW'($urandom);
          pd[i] = $urandom;
          set_m(i, ps[i], pa[i], pd[i]);
          pend[i]  = 1'b1;
          m_req[i] = 1'b1;
        end
      end
      bus_busy  = (busy_left > 0);
      bus_ready = 1'b0;
      bus_id    = '0;
      bus_rdata = $urandom;
      rd_done   = 1'b0;
      if (e_req && ps[e_id] != '0) begin
        bus_ready = 1'b1;
        bus_id    = IdW'(e_id);
      end else if (rd_pend && busy_left == 1) begin
        bus_ready = 1'b1;
        bus_id    = IdW'(rd_id);
        rd_done   = 1'b1;
      end
      exp_rdy = '0;
      if (bus_ready) exp_rdy[bus_id] = 1'b1;
      #1;
      n_chk++;
      if (bus_reqo !== e_req || m_acko !== e_ack)
        $display("FAIL rnd_issue: cycle %0d reqo=%b acko=%b want %b/%b", cyc, bus_reqo, m_acko, e_req, e_ack);
      else n_pass++;
      n_chk++;
      if (m_readyo !== exp_rdy || (bus_ready && m_rdatao !== bus_rdata))
        $display("FAIL rnd_route: cycle %0d readyo=%b rdata=%h want %b/%h", cyc, m_readyo, m_rdatao, exp_rdy, bus_rdata);
      else n_pass++;
      if (e_req) begin
        n_chk++;
        if (bus_ido !== IdW'(e_id) || bus_strbo !== ps[e_id] || bus_addro !== pa[e_id] || bus_wdatao !== pd[e_id])
          $display("FAIL rnd_payload: cycle %0d id=%0d strb=%h addr=%h data=%h want %0d/%h/%h/%h",
                   cyc, bus_ido, bus_strbo, bus_addro, bus_wdatao, e_id, ps[e_id], pa[e_id], pd[e_id]);
        else n_pass++;
      end
      just_ack = e_ack;
      if (busy_left > 0) busy_left--;
      if (rd_done) rd_pend = 1'b0;
      g = -1;
      if (!bus_busy && !e_req) begin
        for (int k = 0; k < NumMst; k++) begin
          if (g < 0 && m_req[(e_ptr + k) % NumMst]) g = (e_ptr + k) % NumMst;
        end
      end
      if (e_req) begin
        busy_left = $urandom_range(1, 4);
        if (ps[e_id] == '0) begin
          rd_pend = 1'b1;
          rd_id   = e_id;
        end
      end
      if (g >= 0) begin
        e_req    = 1'b1;
        e_id     = g;
        e_ack    = '0;
        e_ack[g] = 1'b1;
        e_ptr    = (g + 1) % NumMst;
      end else begin
        e_req = 1'b0;
        e_ack = '0;
      end
      if (cyc >= 400 && pend == '0 && just_ack == '0 && busy_left == 0 && !e_req && !rd_pend) done = 1'b1;
      tick();
    end
    m_req     = '0;
    bus_busy  = 1'b0;
    bus_ready = 1'b0;
    n_chk++;
    if (!done) $display("FAIL rnd_drain: traffic did not drain within budget, pending=%b want 0000", pend);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_single_read();
    test_wrap_skip();
    test_back_pressure();
    test_reset_mid();
    test_random(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
